// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_pkg
// Description : Shared widths and arbiter state encoding for the MIPS bus.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mips_bus_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arb_pick
// Description : Combinational grant selection: M1 preferred, M0 forced when starved.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_arb_pick
    import mips_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1
) (
    input  logic             m0_pending,
    input  logic             m1_pending,
    input  logic [CNT_W-1:0] starve_cnt,
    output arb_state_t       next_grant
);

    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(STARVE_LIMIT);

    always_comb begin
        next_grant = IDLE;
        if (m0_pending && (starve_cnt == c_LIMIT)) begin
            next_grant = GNT_M0;
        end else if (m1_pending) begin
            next_grant = GNT_M1;
        end else if (m0_pending) begin
            next_grant = GNT_M0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arbiter
// Description : Two-master (ifetch M0 / data M1) arbiter onto one memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              s_read,
    output logic              s_write,
    output logic [ADDR_W-1:0] s_address,
    output logic [BE_W-1:0]   s_byteenable,
    output logic [DATA_W-1:0] s_writedata,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    output logic [1:0]        grant
);

    localparam int               c_CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    arb_state_t         w_pick;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic [c_CNT_W-1:0] w_starve_cnt_nxt;
    logic               w_m0_pend;
    logic               w_m1_pend;

    assign w_m0_pend = m0_read | m0_write;
    assign w_m1_pend = m1_read | m1_write;

    mips_bus_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (c_CNT_W)
    ) u_pick (
        .m0_pending (w_m0_pend),
        .m1_pending (w_m1_pend),
        .starve_cnt (r_starve_cnt),
        .next_grant (w_pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_next_state;
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

    // A grant ends on completion or when its owner abandons the request.
    always_comb begin
        w_next_state     = r_state;
        w_starve_cnt_nxt = r_starve_cnt;
        case (r_state)
            IDLE: begin
                w_next_state = w_pick;
                if ((w_pick == GNT_M1) && w_m0_pend) begin
                    if (r_starve_cnt != c_LIMIT) begin
                        w_starve_cnt_nxt = r_starve_cnt + 1'b1;
                    end
                end else if (w_pick != IDLE) begin
                    w_starve_cnt_nxt = '0;
                end
            end
            GNT_M0: begin
                if (!w_m0_pend || !s_waitrequest) begin
                    w_next_state = IDLE;
                end
            end
            GNT_M1: begin
                if (!w_m1_pend || !s_waitrequest) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Write wins over read when a master asserts both.
    always_comb begin
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_address      = '0;
        s_byteenable   = '0;
        s_writedata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        grant          = 2'b00;
        case (r_state)
            GNT_M0: begin
                s_read         = m0_read & ~m0_write;
                s_write        = m0_write;
                s_address      = m0_address;
                s_byteenable   = m0_byteenable;
                s_writedata    = m0_writedata;
                m0_waitrequest = s_waitrequest;
                grant          = 2'b01;
            end
            GNT_M1: begin
                s_read         = m1_read & ~m1_write;
                s_write        = m1_write;
                s_address      = m1_address;
                s_byteenable   = m1_byteenable;
                s_writedata    = m1_writedata;
                m1_waitrequest = s_waitrequest;
                grant          = 2'b10;
            end
            default: ;
        endcase
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_arbiter
// Description : Directed bench with a transaction-level owner/starvation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_bus_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic [3:0]  s_byteenable;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    // model: owner 0 = none, 1 = M0, 2 = M1
    int m_owner = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = 0;
            m_cnt   = 0;
        end else begin
            bit p0, p1;
            int nxt;
            p0 = m0_read | m0_write;
            p1 = m1_read | m1_write;
            if (m_owner == 0) begin
                if (p0 && m_cnt == STARVE_LIMIT) nxt = 1;
                else if (p1)                      nxt = 2;
                else if (p0)                      nxt = 1;
                else                              nxt = 0;
                if (nxt == 2 && p0)  m_cnt = (m_cnt < STARVE_LIMIT) ? m_cnt + 1 : STARVE_LIMIT;
                else if (nxt != 0)   m_cnt = 0;
                m_owner = nxt;
            end else if (m_owner == 1) begin
                if (!p0 || !s_waitrequest) m_owner = 0;
            end else begin
                if (!p1 || !s_waitrequest) m_owner = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic [5:0]  e_ctl;
            logic [67:0] e_dat;
            logic        r, w;
            r = (m_owner == 1) ? m0_read  : (m_owner == 2) ? m1_read  : 1'b0;
            w = (m_owner == 1) ? m0_write : (m_owner == 2) ? m1_write : 1'b0;
            e_ctl = {(m_owner == 2), (m_owner == 1), r & ~w, w,
                     (m_owner == 1) ? s_waitrequest : 1'b1,
                     (m_owner == 2) ? s_waitrequest : 1'b1};
            e_dat = (m_owner == 1) ? {m0_address, m0_byteenable, m0_writedata} :
                    (m_owner == 2) ? {m1_address, m1_byteenable, m1_writedata} : 68'd0;
            chk("cyc_ctl", {26'd0, grant, s_read, s_write, m0_waitrequest, m1_waitrequest}, {26'd0, e_ctl});
            chk("cyc_addr_be", {s_address[27:0], s_byteenable}, {e_dat[63:36], e_dat[35:32]});
            chk("cyc_addr_hi", {28'd0, s_address[31:28]}, {28'd0, e_dat[67:64]});
            chk("cyc_wdata", s_writedata, e_dat[31:0]);
            chk("cyc_rdata", m0_readdata ^ m1_readdata ^ s_readdata, s_readdata);
        end
    end

    initial begin
        reset = 1'b1;
        {m0_read, m0_write, m1_read, m1_write} = 4'b0;
        m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b1;
        s_readdata    = '0;

        // reset holds everything idle even with a request present
        repeat (2) @(posedge clk);
        #1 m1_read = 1'b1;
        #1;
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_srw", {30'd0, s_read, s_write}, 32'd0);
        chk("rst_wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
        m1_read = 1'b0;
        reset   = 1'b0;
        step();

        // single M0 read with two wait cycles
        m0_read = 1'b1; m0_address = 32'hBFC00000; m0_byteenable = 4'hF;
        s_readdata = 32'h24020005; s_waitrequest = 1'b1;
        #1 chk("s1_req_idle", {30'd0, grant}, 32'd0);
        step();
        chk("s1_grant", {30'd0, grant}, 32'd1);
        chk("s1_wait_hi", {31'd0, m0_waitrequest}, 32'd1);
        chk("s1_addr", s_address, 32'hBFC00000);
        step();
        chk("s1_grant2", {30'd0, grant}, 32'd1);
        s_waitrequest = 1'b0;
        #1;
        chk("s1_wait_lo", {31'd0, m0_waitrequest}, 32'd0);
        chk("s1_rdata", m0_readdata, 32'h24020005);
        step();
        m0_read = 1'b0; s_waitrequest = 1'b1;
        #1 chk("s1_idle", {30'd0, grant}, 32'd0);

        // simultaneous M0 read and M1 write: M1 first
        m0_read = 1'b1;
        m1_write = 1'b1; m1_address = 32'h00001000; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'hF;
        s_waitrequest = 1'b0;
        step();
        chk("s2_grant_m1", {30'd0, grant}, 32'd2);
        chk("s2_swrite", {31'd0, s_write}, 32'd1);
        chk("s2_wdata", s_writedata, 32'hDEADBEEF);
        chk("s2_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
        step();
        m1_write = 1'b0;
        #1 chk("s2_idle", {30'd0, grant}, 32'd0);
        step();
        chk("s2_grant_m0", {30'd0, grant}, 32'd1);
        step();
        m0_read = 1'b0;

        // starvation: four M1 grants, then M0 is forced
        m0_read = 1'b1; m1_read = 1'b1; s_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s3_m1_win", {30'd0, grant}, 32'd2);
            step();
        end
        step();
        chk("s3_m0_forced", {30'd0, grant}, 32'd1);
        chk("s3_cnt_model", m_cnt, 32'd0);
        chk("s3_cnt_dut", {29'd0, dut.r_starve_cnt}, m_cnt);
        m0_read = 1'b0; m1_read = 1'b0;
        step();
        step();

        // asynchronous reset in the middle of an M1 write
        m1_write = 1'b1; m1_address = 32'h00002000; s_waitrequest = 1'b1;
        step();
        chk("s4_swrite", {31'd0, s_write}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("s4_abort_sw", {31'd0, s_write}, 32'd0);
        chk("s4_abort_gnt", {30'd0, grant}, 32'd0);
        reset = 1'b0;
        step();
        chk("s4_regrant", {30'd0, grant}, 32'd2);
        s_waitrequest = 1'b0;
        step();
        m1_write = 1'b0; s_waitrequest = 1'b1;

        // read+write together, then abandoned mid-grant
        m1_read = 1'b1; m1_write = 1'b1;
        step();
        chk("s5_rw", {30'd0, s_read, s_write}, 32'd1);
        m1_read = 1'b0; m1_write = 1'b0;
        #1 chk("s5_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
        step();
        chk("s5_idle", {30'd0, grant}, 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive M1 grants allowed while M0 is pending before M0 is forced.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port m0_read / m0_write  in  1 each  instruction-fetch master requests.
REQ-005 SHALL have port m0_address  in  32, m0_byteenable  in  4, m0_writedata  in  32.
REQ-006 SHALL have port m0_waitrequest  out  1, m0_readdata  out  32.
REQ-007 SHALL have port m1_read / m1_write  in  1 each  data-access master requests; m1_address  in  32, m1_byteenable  in  4, m1_writedata  in  32.
REQ-008 SHALL have port m1_waitrequest  out  1, m1_readdata  out  32.
REQ-009 SHALL have port s_read / s_write  out  1 each, s_address  out  32, s_byteenable  out  4, s_writedata  out  32  toward memory.
REQ-010 SHALL have port s_waitrequest  in  1, s_readdata  in  32.
REQ-011 SHALL have port grant  out  2  one-hot current owner: bit0 = M0, bit1 = M1, 00 = idle.

Function
REQ-012 SHALL implement states IDLE, GNT_M0, GNT_M1.
- A master is pending when its read or write is 1.
REQ-013 In IDLE: s_read = s_write = 0; both mN_waitrequest = 1; grant = 00.
REQ-014 In IDLE with any master pending, the next edge SHALL enter a grant state. Arbitration latency is 1 cycle.
- Default choice: M1 if pending, else M0.
- Override: M0 if M0 is pending and starve_cnt == STARVE_LIMIT.
REQ-015 In GNT_x: s_* is combinationally driven from master x.
- mx_waitrequest = s_waitrequest.
- The other master's waitrequest = 1.
- grant = one-hot x.
REQ-016 A transfer SHALL complete on the edge where the state is GNT_x, master x is pending and s_waitrequest = 0. That edge returns to IDLE, so the minimum is 2 cycles per transfer.
REQ-017 If master x drops both read and write while in GNT_x (protocol violation), the next edge SHALL return to IDLE. s_read/s_write follow the master combinationally.
REQ-018 If a granted master asserts read and write together, s_write SHALL be forwarded and s_read forced to 0.
REQ-019 s_readdata SHALL be broadcast to m0_readdata and m1_readdata unmodified. It is meaningful only to the granted master on its completion edge.
REQ-020 starve_cnt rules:
- Width is $clog2(STARVE_LIMIT+1).
- Increments on each transition IDLE->GNT_M1 while M0 is pending, saturating at STARVE_LIMIT.
- Clears on IDLE->GNT_M0, or on IDLE->GNT_M1 with M0 not pending.
REQ-021 A master SHALL never observe waitrequest = 0 unless it is granted. No slave signal SHALL change owner mid-transfer.

Reset
REQ-022 While reset = 1, regardless of clk:
- state = IDLE, starve_cnt = 0, grant = 00.
- s_read = s_write = 0, both mN_waitrequest = 1.
REQ-023 Reset asserted mid-transfer SHALL drop s_read/s_write immediately (asynchronously). There is no completion for the aborted master.
REQ-024 The first arbitration SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-025 A shared package mips_bus_pkg SHALL hold:
- ADDR_W = 32, DATA_W = 32, BE_W = 4.
- The arb_state_t enum {IDLE, GNT_M0, GNT_M1}.
REQ-026 One sub-module, mips_bus_arb_pick, SHALL be purely combinational. Inputs: m0 pending, m1 pending, starve_cnt. Output: next grant.
REQ-027 Output muxing and the FSM SHALL reside in mips_bus_arbiter. The total design SHALL be 120-400 lines.

Verification
REQ-028 Single M0 read, addr 0xBFC00000, s_waitrequest held 1 for 2 cycles:
- grant = 01 one cycle after request.
- m0_waitrequest falls with s_waitrequest.
- m0_readdata = 0x24020005 on the completion edge.
- Return to IDLE; 4 cycles total.
REQ-029 M0 read and M1 write (addr 0x00001000, data 0xDEADBEEF, be 0xF) requested in the same cycle:
- M1 is granted first; s_write = 1 with M1 values.
- M0 waitrequest stays 1 until M1 completes.
- M0 is granted after the next IDLE.
REQ-030 STARVE_LIMIT = 4, M1 requesting back-to-back and M0 pending:
- M1 wins 4 grants.
- The 5th arbitration grants M0.
- starve_cnt reads 0 after the M0 grant.
REQ-031 Reset pulsed while GNT_M1 with s_write = 1:
- s_write = 0 and grant = 00 within the same time step, before the next clk edge.
- After release, a still-pending M1 is granted on the first edge.
REQ-032 M1 asserts read and write together:
- s_write = 1, s_read = 0.
- M1 drops requests mid-grant with s_waitrequest = 1 -> IDLE on the next edge, with no waitrequest = 0 pulse to M0.
